// File: rtl/cnn_pkg.sv
// Shared widths and saturation limits for the EEG CNN feature-extractor blocks.
package cnn_pkg;

    localparam int CNN_DATA_W = 8;
    localparam int CNN_WGT_W  = 8;
    localparam int CNN_ACC_W  = 20;
    localparam int CNN_OUT_W  = 16;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_relu_sat.sv
// Combinational ReLU / saturation stage narrowing the accumulator to the output width.
module pe_relu_sat
    import cnn_pkg::*;
#(
    parameter int RELU  = 1,
    parameter int ACC_W = CNN_ACC_W,
    parameter int OUT_W = CNN_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] res_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(sat_min(OUT_W));
    localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(sat_max(OUT_W));
    localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(sat_min(OUT_W));

    always_comb begin
        res_o = acc_i[OUT_W-1:0];
        sat_o = 1'b0;
        // A ReLU-clamped negative is a legal zero, not a clip.
        if (RELU != 0 && acc_i < 0) begin
            res_o = '0;
        end else if (acc_i > MAX_A) begin
            res_o = MAX_O;
            sat_o = 1'b1;
        end else if (acc_i < MIN_A) begin
            res_o = MIN_O;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/conv1d_pe.sv
// Streaming 1-D convolution PE: TAPS-deep sample window, signed MAC with bias,
// ReLU/saturation, stride decimation and valid/ready flow control.
module conv1d_pe
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int WGT_W  = CNN_WGT_W,
    parameter int TAPS   = 3,
    parameter int ACC_W  = CNN_ACC_W,
    parameter int OUT_W  = CNN_OUT_W,
    parameter int STRIDE = 1,
    parameter int RELU   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic [TAPS*WGT_W-1:0]     weight,
    input  logic signed [WGT_W-1:0]   bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat
);

    localparam int PROD_W = DATA_W + WGT_W;
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);
    localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE - 1);

    if (TAPS < 2) begin : g_bad_taps
        $error("conv1d_pe: TAPS must be >= 2");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("conv1d_pe: STRIDE must be >= 1");
    end
    if (ACC_W < PROD_W + $clog2(TAPS + 1)) begin : g_bad_acc
        $error("conv1d_pe: ACC_W too narrow for TAPS products plus bias");
    end
    if (OUT_W > ACC_W) begin : g_bad_out
        $error("conv1d_pe: OUT_W must not exceed ACC_W");
    end

    logic                     adv;
    logic                     accept;
    logic                     win_full;
    logic                     fire;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [STR_W-1:0]         stride_q, stride_d;
    logic signed [DATA_W-1:0] win_q [TAPS];
    logic                     vld_p0_q;
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [PROD_W-1:0] prod_p1_q [TAPS];
    logic                     vld_p1_q;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [OUT_W-1:0]  res_p1;
    logic                     sat_p1;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic                     out_sat_q;

    assign adv      = en & (~out_valid_q | out_ready);
    assign in_ready = adv & rst & ~clear;
    assign accept   = in_valid & in_ready;

    // Fill saturates at TAPS; the stride counter only runs once the window is complete,
    // so phase 0 always lands on the first complete window.
    always_comb begin
        fill_d   = fill_q;
        stride_d = stride_q;
        win_full = 1'b0;
        fire     = 1'b0;
        if (accept) begin
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            win_full = (fill_d == FILL_FULL);
            if (win_full) begin
                fire     = (stride_q == '0);
                stride_d = (stride_q == STR_LAST) ? '0 : stride_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(win_q[k]) * PROD_W'($signed(weight[k*WGT_W +: WGT_W]));
        end
    end

    // ---- p0: window shift and control ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q      <= '0;
            stride_q    <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else if (en) begin
            if (clear) begin
                fill_q      <= '0;
                stride_q    <= '0;
                vld_p0_q    <= 1'b0;
                vld_p1_q    <= 1'b0;
                out_valid_q <= 1'b0;
                for (int k = 0; k < TAPS; k++) begin
                    win_q[k] <= '0;
                end
            end else if (adv) begin
                if (accept) begin
                    for (int k = 0; k < TAPS - 1; k++) begin
                        win_q[k] <= win_q[k+1];
                    end
                    win_q[TAPS-1] <= in_data;
                    fill_q        <= fill_d;
                    stride_q      <= stride_d;
                end
                vld_p0_q    <= fire;
                vld_p1_q    <= vld_p0_q;
                // ---- p2: registered thresholded result ----
                out_valid_q <= vld_p1_q;
                if (vld_p1_q) begin
                    out_data_q <= res_p1;
                    out_sat_q  <= sat_p1;
                end
            end
        end
    end

    // ---- p1: product registers (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_p1_q[k] <= prod_d[k];
            end
        end
    end

    always_comb begin
        acc_p1 = ACC_W'(bias);
        for (int k = 0; k < TAPS; k++) begin
            acc_p1 = acc_p1 + ACC_W'(prod_p1_q[k]);
        end
    end

    pe_relu_sat #(
        .RELU  (RELU),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_relu_sat (
        .acc_i (acc_p1),
        .res_o (res_p1),
        .sat_o (sat_p1)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
